io_mod_pwm_multi: RTL and testbench

Memory-mapped robot I/O peripheral sitting between the core's data-memory port and the board pins. It provides a GPIO output register, a two-flop-synchronised GPIO input register, and NUM_PWM independent hardware PWM generators with a shared prescaler and glitch-free, wrap-aligned duty updates. An optional sticky rising-edge detector drives an interrupt line. Accesses outside its address window pass through to data memory unchanged.

---
 rtl/io_mod_pwm_multi.sv | 160 ++++++++++++++++
 tb/tb_io_mod_pwm_multi.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mod_pwm_multi.sv
// Memory-mapped robot I/O: GPIO out, synchronised GPIO in, NUM_PWM PWM channels with a shared prescaler.
// Define IO_EDGE_IRQ_EN to build the sticky rising-edge detector, IRQ mask and irq output.
module io_mod_pwm_multi #(
   parameter int          NUM_PWM    = 4,
   parameter int          PWM_WIDTH  = 8,
   parameter int          GPIO_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = 32'hFFFFFF00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_mem,
   input  logic                  read_mem,
   input  logic [31:0]           data_address,
   input  logic [31:0]           data_to_write,
   input  logic [31:0]           data_from_mem,
   output logic [31:0]           data_read,
   input  logic [GPIO_WIDTH-1:0] io_in,
   output logic [GPIO_WIDTH-1:0] io_out,
   output logic [NUM_PWM-1:0]    pwm_out,
   output logic                  irq
);
   localparam logic [3:0] W_GPIO_OUT = 4'h0;
   localparam logic [3:0] W_GPIO_IN  = 4'h1;
   localparam logic [3:0] W_EDGE     = 4'h2;
   localparam logic [3:0] W_PWM_EN   = 4'h3;
   localparam logic [3:0] W_PRESCALE = 4'h4;
   localparam logic [3:0] W_IRQ_MASK = 4'h5;

   logic                  in_window;
   logic [3:0]            word;
   logic                  wr;
   logic                  hit;
   logic [31:0]           reg_rdata;

   logic [GPIO_WIDTH-1:0] gpio_out_reg;
   logic [GPIO_WIDTH-1:0] sync1_reg;
   logic [GPIO_WIDTH-1:0] sync2_reg;
   logic [NUM_PWM-1:0]    pwm_en_reg;
   logic [15:0]           prescale_reg;
   logic [15:0]           presc_cnt_reg;
   logic [PWM_WIDTH-1:0]  pwm_cnt_reg;
   logic                  tick;
   logic                  wrap;
   logic [GPIO_WIDTH-1:0] edge_rd;
   logic [GPIO_WIDTH-1:0] mask_rd;
   logic [NUM_PWM-1:0][PWM_WIDTH-1:0] duty_all;

   // Only exact, word-aligned addresses inside the 64-byte window can hit
   assign in_window = (data_address[31:6] == BASE_ADDR[31:6]) && (data_address[1:0] == 2'b00);
   assign word      = data_address[5:2];
   assign wr        = write_mem && in_window;

   assign tick = (presc_cnt_reg == prescale_reg);
   assign wrap = tick && (pwm_cnt_reg == {PWM_WIDTH{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio_out_reg  <= '0;
         sync1_reg     <= '0;
         sync2_reg     <= '0;
         pwm_en_reg    <= '0;
         prescale_reg  <= '0;
         presc_cnt_reg <= '0;
         pwm_cnt_reg   <= '0;
      end else begin
         sync1_reg <= io_in;
         sync2_reg <= sync1_reg;
         if (wr && word == W_GPIO_OUT) gpio_out_reg <= data_to_write[GPIO_WIDTH-1:0];
         if (wr && word == W_PWM_EN)   pwm_en_reg   <= data_to_write[NUM_PWM-1:0];
         if (wr && word == W_PRESCALE) prescale_reg <= data_to_write[15:0];
         // Shrinking PRESCALE below the running count restarts the prescaler
         if (wr && word == W_PRESCALE && data_to_write[15:0] < presc_cnt_reg)
            presc_cnt_reg <= '0;
         else if (tick)
            presc_cnt_reg <= '0;
         else
            presc_cnt_reg <= presc_cnt_reg + 16'd1;
         if (tick) pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_PWM; gi++) begin : g_ch
         logic                 wr_duty;
         logic [PWM_WIDTH-1:0] duty_reg;
         logic [PWM_WIDTH-1:0] shadow_reg;

         assign wr_duty = wr && (word == 4'(8 + gi));

         // Shadow only changes on wrap, so a period is never cut short; a write on the wrap wins
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               duty_reg   <= '0;
               shadow_reg <= '0;
            end else begin
               if (wr_duty) duty_reg <= data_to_write[PWM_WIDTH-1:0];
               if (wrap) shadow_reg <= wr_duty ? data_to_write[PWM_WIDTH-1:0] : duty_reg;
            end
         end

         assign duty_all[gi] = duty_reg;
         assign pwm_out[gi]  = pwm_en_reg[gi] && (pwm_cnt_reg < shadow_reg);
      end
   endgenerate

`ifdef IO_EDGE_IRQ_EN
   logic [GPIO_WIDTH-1:0] sync3_reg;
   logic [GPIO_WIDTH-1:0] edge_reg;
   logic [GPIO_WIDTH-1:0] mask_reg;
   logic [GPIO_WIDTH-1:0] clr_bits;

   assign clr_bits = (wr && word == W_EDGE) ? data_to_write[GPIO_WIDTH-1:0] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync3_reg <= '0;
         edge_reg  <= '0;
         mask_reg  <= '0;
      end else begin
         sync3_reg <= sync2_reg;
         // New rising edges take priority over a same-cycle clear
         edge_reg  <= (edge_reg & ~clr_bits) | (sync2_reg & ~sync3_reg);
         if (wr && word == W_IRQ_MASK) mask_reg <= data_to_write[GPIO_WIDTH-1:0];
      end
   end

   assign edge_rd = edge_reg;
   assign mask_rd = mask_reg;
   assign irq     = |(edge_reg & mask_reg);
`else
   assign edge_rd = '0;
   assign mask_rd = '0;
   assign irq     = 1'b0;
`endif

   always_comb begin
      hit       = 1'b0;
      reg_rdata = '0;
      if (in_window) begin
         case (word)
            W_GPIO_OUT: begin hit = 1'b1; reg_rdata = 32'(gpio_out_reg);  end
            W_GPIO_IN:  begin hit = 1'b1; reg_rdata = 32'(sync2_reg);     end
            W_EDGE:     begin hit = 1'b1; reg_rdata = 32'(edge_rd);       end
            W_PWM_EN:   begin hit = 1'b1; reg_rdata = 32'(pwm_en_reg);    end
            W_PRESCALE: begin hit = 1'b1; reg_rdata = 32'(prescale_reg);  end
            W_IRQ_MASK: begin hit = 1'b1; reg_rdata = 32'(mask_rd);       end
            default:    ;
         endcase
         for (int i = 0; i < NUM_PWM; i++) begin
            if (word == 4'(8 + i)) begin
               hit       = 1'b1;
               reg_rdata = 32'(duty_all[i]);
            end
         end
      end
   end

   assign data_read = (read_mem && !write_mem && hit) ? reg_rdata : data_from_mem;
   assign io_out    = gpio_out_reg;
endmodule

// File: tb/tb_io_mod_pwm_multi.sv
// Scoreboard bench for io_mod_pwm_multi: register map, GPIO, PWM waveforms, async reset and edge irq.
module tb_io_mod_pwm_multi;
   localparam int          NUM_PWM    = 4;
   localparam int          PWM_WIDTH  = 8;
   localparam int          GPIO_WIDTH = 32;
   localparam logic [31:0] BASE       = 32'hFFFFFF00;

   logic                  clk;
   logic                  rst;
   logic                  write_mem;
   logic                  read_mem;
   logic [31:0]           data_address;
   logic [31:0]           data_to_write;
   logic [31:0]           data_from_mem;
   logic [31:0]           data_read;
   logic [GPIO_WIDTH-1:0] io_in;
   logic [GPIO_WIDTH-1:0] io_out;
   logic [NUM_PWM-1:0]    pwm_out;
   logic                  irq;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got;
   logic [31:0] exp_v;

   io_mod_pwm_multi #(
      .NUM_PWM(NUM_PWM), .PWM_WIDTH(PWM_WIDTH), .GPIO_WIDTH(GPIO_WIDTH), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst), .write_mem(write_mem), .read_mem(read_mem),
      .data_address(data_address), .data_to_write(data_to_write),
      .data_from_mem(data_from_mem), .data_read(data_read),
      .io_in(io_in), .io_out(io_out), .pwm_out(pwm_out), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time=%0t required=finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
      data_address  = BASE + {24'h0, off};
      data_to_write = d;
      write_mem     = 1'b1;
      @(posedge clk); #1;
      write_mem = 1'b0;
      $display("write off=%02h data=%08h", off, d);
   endtask

   task automatic bus_read(input logic [31:0] addr, input logic [31:0] dfm, output logic [31:0] d);
      data_address  = addr;
      data_from_mem = dfm;
      read_mem      = 1'b1;
      #2;
      d        = data_read;
      read_mem = 1'b0;
      $display("read addr=%08h data=%08h", addr, d);
   endtask

   task automatic wait_rise(input int ch, output bit ok);
      logic prev;
      ok = 1'b0;
      @(negedge clk);
      prev = pwm_out[ch];
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!prev && pwm_out[ch]) begin
            ok = 1'b1;
            break;
         end
         prev = pwm_out[ch];
      end
   endtask

   task automatic count_level(input int ch, input logic lvl, output int n, output bit ok);
      n  = 1;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (pwm_out[ch] == lvl) n++;
         else begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic measure(input int ch, output int h, output int l, output bit ok);
      bit ok1, ok2, ok3;
      wait_rise(ch, ok1);
      count_level(ch, 1'b1, h, ok2);
      count_level(ch, 1'b0, l, ok3);
      ok = ok1 && ok2 && ok3;
      $display("pwm ch=%0d high=%0d low=%0d", ch, h, l);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1; write_mem = 1'b0; read_mem = 1'b0;
      data_address = '0; data_to_write = '0; data_from_mem = '0; io_in = '0;
      repeat (3) @(posedge clk);
      #1;
      exp_q.push_back(32'h0);
      got = {31'h0, irq} | {28'h0, pwm_out} | io_out; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL reset_outputs: got=%h expected=%h", got, exp_v); end
      rst = 1'b0;
      for (int off = 0; off < 64; off += 4) begin
         exp_q.push_back(32'h0);
         bus_read(BASE + 32'(off), 32'h0, d);
         exp_v = exp_q.pop_front(); checks++;
         if (d !== exp_v) begin failures++; $display("FAIL reset_read_%0h: got=%h expected=%h", off, d, exp_v); end
      end
      exp_q.push_back(32'h12345678);
      bus_read(32'h0000_0100, 32'h12345678, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL passthru_outside: got=%h expected=%h", d, exp_v); end
      exp_q.push_back(32'hCAFEF00D);
      bus_read(BASE + 32'h18, 32'hCAFEF00D, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL passthru_unimpl: got=%h expected=%h", d, exp_v); end
      exp_q.push_back(32'h0BADC0DE);
      bus_read(BASE + 32'h01, 32'h0BADC0DE, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL passthru_unaligned: got=%h expected=%h", d, exp_v); end
      exp_q.push_back(32'h11112222);
      bus_read(BASE + 32'h30, 32'h11112222, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL passthru_duty4: got=%h expected=%h", d, exp_v); end
   endtask

   task automatic test_gpio();
      logic [31:0] d;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'hA5A5A5A5);
      data_address = BASE; data_to_write = 32'hA5A5A5A5; write_mem = 1'b1;
      #2;
      got = io_out; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL gpio_out_before_edge: got=%h expected=%h", got, exp_v); end
      @(posedge clk); #1;
      write_mem = 1'b0;
      got = io_out; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL gpio_out_after_edge: got=%h expected=%h", got, exp_v); end
      // simultaneous read and write: write lands, read returns memory data
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h5A5A5A5A);
      data_to_write = 32'h5A5A5A5A; data_from_mem = 32'hDEADBEEF; write_mem = 1'b1; read_mem = 1'b1;
      #2;
      got = data_read; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL rw_collision_read: got=%h expected=%h", got, exp_v); end
      @(posedge clk); #1;
      write_mem = 1'b0; read_mem = 1'b0;
      got = io_out; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL rw_collision_write: got=%h expected=%h", got, exp_v); end
      exp_q.push_back(32'h5A5A5A5A);
      bus_read(BASE, 32'hFFFFFFFF, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL gpio_out_readback: got=%h expected=%h", d, exp_v); end
      exp_q.push_back(32'h0);
      bus_write(8'h04, 32'hFFFFFFFF);
      bus_read(BASE + 32'h04, 32'h77777777, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL gpio_in_write_ignored: got=%h expected=%h", d, exp_v); end
      // two-flop synchroniser latency
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h80000003);
      io_in = 32'h80000003;
      data_address = BASE + 32'h04; read_mem = 1'b1;
      @(posedge clk); #1;
      got = data_read; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL gpio_in_1edge: got=%h expected=%h", got, exp_v); end
      @(posedge clk); #1;
      got = data_read; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL gpio_in_2edge: got=%h expected=%h", got, exp_v); end
      read_mem = 1'b0;
   endtask

   task automatic test_pwm();
      int h, l, n;
      bit ok;
      logic [31:0] d;
      bus_write(8'h10, 32'd0);
      bus_write(8'h20, 32'd64);
      bus_write(8'h0C, 32'd1);
      exp_q.push_back(32'd1);
      bus_read(BASE + 32'h0C, 32'h0, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL pwm_en_readback: got=%h expected=%h", d, exp_v); end
      exp_q.push_back(32'd1); exp_q.push_back(32'd64); exp_q.push_back(32'd192);
      measure(0, h, l, ok);
      exp_v = exp_q.pop_front(); checks++;
      if (32'(ok) !== exp_v) begin failures++; $display("FAIL duty64_timeout: got=%0d expected=%0d", ok, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(h) !== exp_v) begin failures++; $display("FAIL duty64_high: got=%0d expected=%0d", h, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(l) !== exp_v) begin failures++; $display("FAIL duty64_low: got=%0d expected=%0d", l, exp_v); end
      bus_write(8'h20, 32'd255);
      exp_q.push_back(32'd1); exp_q.push_back(32'd255); exp_q.push_back(32'd1);
      measure(0, h, l, ok);
      exp_v = exp_q.pop_front(); checks++;
      if (32'(ok) !== exp_v) begin failures++; $display("FAIL duty255_timeout: got=%0d expected=%0d", ok, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(h) !== exp_v) begin failures++; $display("FAIL duty255_high: got=%0d expected=%0d", h, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(l) !== exp_v) begin failures++; $display("FAIL duty255_low: got=%0d expected=%0d", l, exp_v); end
      bus_write(8'h20, 32'd0);
      exp_q.push_back(32'd0);
      repeat (300) @(negedge clk);
      n = 0;
      repeat (600) begin
         @(negedge clk);
         if (pwm_out[0]) n++;
      end
      $display("pwm ch=0 duty0 high_samples=%0d", n);
      exp_v = exp_q.pop_front(); checks++;
      if (32'(n) !== exp_v) begin failures++; $display("FAIL duty0_high: got=%0d expected=%0d", n, exp_v); end
   endtask

   task automatic test_duty_update();
      int h1, l1, h2, h, l;
      bit ok1, ok2, ok3, ok4, ok;
      bus_write(8'h20, 32'd64);
      exp_q.push_back(32'd1); exp_q.push_back(32'd64); exp_q.push_back(32'd192); exp_q.push_back(32'd128);
      wait_rise(0, ok1);
      fork
         begin
            count_level(0, 1'b1, h1, ok2);
            count_level(0, 1'b0, l1, ok3);
            count_level(0, 1'b1, h2, ok4);
         end
         begin
            repeat (10) @(posedge clk);
            #1;
            bus_write(8'h20, 32'd128);
         end
      join
      $display("pwm ch=0 midupdate high=%0d low=%0d next_high=%0d", h1, l1, h2);
      exp_v = exp_q.pop_front(); checks++;
      if (32'(ok1 && ok2 && ok3 && ok4) !== exp_v) begin failures++; $display("FAIL midupdate_timeout: got=0 expected=%0d", exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(h1) !== exp_v) begin failures++; $display("FAIL midupdate_cur_high: got=%0d expected=%0d", h1, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(l1) !== exp_v) begin failures++; $display("FAIL midupdate_cur_low: got=%0d expected=%0d", l1, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(h2) !== exp_v) begin failures++; $display("FAIL midupdate_next_high: got=%0d expected=%0d", h2, exp_v); end
      // prescale 3: tick every 4 cycles, 1024-cycle period
      bus_write(8'h10, 32'd3);
      exp_q.push_back(32'd1); exp_q.push_back(32'd512); exp_q.push_back(32'd512);
      measure(0, h, l, ok);
      exp_v = exp_q.pop_front(); checks++;
      if (32'(ok) !== exp_v) begin failures++; $display("FAIL presc3_timeout: got=%0d expected=%0d", ok, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(h) !== exp_v) begin failures++; $display("FAIL presc3_high: got=%0d expected=%0d", h, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(l) !== exp_v) begin failures++; $display("FAIL presc3_low: got=%0d expected=%0d", l, exp_v); end
      // disabling mid-high forces the output low straight away
      exp_q.push_back(32'd0);
      wait_rise(0, ok);
      bus_write(8'h0C, 32'd0);
      got = {31'h0, pwm_out[0]}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL pwm_en_off: got=%0d expected=%0d", got, exp_v); end
      bus_write(8'h10, 32'd0);
   endtask

   task automatic test_reset_mid_period();
      int n, h, l;
      bit ok;
      logic [31:0] d;
      bus_write(8'h24, 32'd200);
      bus_write(8'h0C, 32'd2);
      exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      wait_rise(1, ok);
      exp_v = exp_q.pop_front(); checks++;
      if (32'(pwm_out[1]) !== exp_v) begin failures++; $display("FAIL reset_mid_precond: got=%0d expected=%0d", pwm_out[1], exp_v); end
      #2 rst = 1'b1;
      #1;
      got = {28'h0, pwm_out}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL reset_mid_pwm: got=%h expected=%h", got, exp_v); end
      got = io_out; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL reset_mid_io_out: got=%h expected=%h", got, exp_v); end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.push_back(32'd0);
      n = 0;
      repeat (600) begin
         @(negedge clk);
         if (pwm_out != '0) n++;
      end
      $display("pwm after reset active_samples=%0d", n);
      exp_v = exp_q.pop_front(); checks++;
      if (32'(n) !== exp_v) begin failures++; $display("FAIL reset_pwm_stays_low: got=%0d expected=%0d", n, exp_v); end
      exp_q.push_back(32'd0);
      bus_read(BASE + 32'h0C, 32'h0, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL reset_pwm_en: got=%h expected=%h", d, exp_v); end
      bus_write(8'h24, 32'd200);
      bus_write(8'h0C, 32'd2);
      exp_q.push_back(32'd1); exp_q.push_back(32'd200); exp_q.push_back(32'd56);
      measure(1, h, l, ok);
      exp_v = exp_q.pop_front(); checks++;
      if (32'(ok) !== exp_v) begin failures++; $display("FAIL ch1_timeout: got=%0d expected=%0d", ok, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(h) !== exp_v) begin failures++; $display("FAIL ch1_high: got=%0d expected=%0d", h, exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (32'(l) !== exp_v) begin failures++; $display("FAIL ch1_low: got=%0d expected=%0d", l, exp_v); end
   endtask

`ifdef IO_EDGE_IRQ_EN
   task automatic test_edge_irq();
      logic [31:0] d;
      bus_write(8'h14, 32'd1);
      io_in = '0;
      repeat (4) @(posedge clk);
      #1;
      bus_write(8'h08, 32'hFFFFFFFF);
      io_in = 32'h1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
      @(posedge clk);
      @(posedge clk); #1;
      got = {31'h0, irq}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL edge_irq_2edge: got=%0d expected=%0d", got, exp_v); end
      @(posedge clk); #1;
      got = {31'h0, irq}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL edge_irq_3edge: got=%0d expected=%0d", got, exp_v); end
      bus_read(BASE + 32'h08, 32'h0, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL edge_reg_set: got=%h expected=%h", d, exp_v); end
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      bus_write(8'h08, 32'h1);
      got = {31'h0, irq}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL edge_clear_irq: got=%0d expected=%0d", got, exp_v); end
      bus_read(BASE + 32'h08, 32'h0, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL edge_clear_reg: got=%h expected=%h", d, exp_v); end
      // new edge landing on the same edge as a clear: set wins
      io_in = '0;
      repeat (4) @(posedge clk);
      #1;
      io_in = 32'h1;
      exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      data_address = BASE + 32'h08; data_to_write = 32'h1; write_mem = 1'b1;
      @(posedge clk); #1;
      write_mem = 1'b0;
      bus_read(BASE + 32'h08, 32'h0, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL edge_set_wins_reg: got=%h expected=%h", d, exp_v); end
      got = {31'h0, irq}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL edge_set_wins_irq: got=%0d expected=%0d", got, exp_v); end
      bus_write(8'h14, 32'd0);
      got = {31'h0, irq}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL edge_masked_off: got=%0d expected=%0d", got, exp_v); end
   endtask
`else
   task automatic test_edge_irq();
      logic [31:0] d;
      bus_write(8'h14, 32'hFFFFFFFF);
      io_in = '0;
      repeat (4) @(posedge clk);
      #1;
      io_in = 32'h1;
      repeat (5) @(posedge clk);
      #1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      got = {31'h0, irq}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin failures++; $display("FAIL noedge_irq: got=%0d expected=%0d", got, exp_v); end
      bus_read(BASE + 32'h08, 32'h55555555, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL noedge_edge_reg: got=%h expected=%h", d, exp_v); end
      bus_read(BASE + 32'h14, 32'h55555555, d);
      exp_v = exp_q.pop_front(); checks++;
      if (d !== exp_v) begin failures++; $display("FAIL noedge_mask_reg: got=%h expected=%h", d, exp_v); end
   endtask
`endif

   initial begin
      test_reset();
      test_gpio();
      test_pwm();
      test_duty_update();
      test_reset_mid_period();
      test_edge_irq();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
